// File: rtl/div.sv
// 32-bit restoring divider for the execute stage: one quotient bit per cycle,
// sign fixup on completion, result held with ready_o until EX drops start_i.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [64:0] w;
    logic [31:0] dvs_mag;
    logic        neg_quot;
    logic        neg_rem;
    logic [32:0] diff;
    logic [64:0] w_next;

    // Two's complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
    function automatic logic [31:0] mag_sel(input logic [31:0] v, input logic is_signed);
        logic signed [31:0] sv;
        sv = v;
        return (is_signed && v[31]) ? 32'(-sv) : v;
    endfunction

    function automatic logic [31:0] neg_sel(input logic [31:0] v, input logic en);
        logic signed [31:0] sv;
        sv = v;
        return en ? 32'(-sv) : v;
    endfunction

    // Trial subtraction of the divisor from the partial remainder.
    always_comb begin
        diff   = w[64:32] - {1'b0, dvs_mag};
        w_next = diff[32] ? {w[63:0], 1'b0} : {diff[31:0], w[31:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            w        <= 65'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        dvs_mag  <= mag_sel(opdata2_i, signed_div_i);
                        neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem  <= signed_div_i & opdata1_i[31];
                        if (opdata2_i == 32'd0) begin
                            state <= S_BYZERO;
                        end else begin
                            state <= S_ON;
                            cnt   <= 6'd0;
                            w     <= {32'd0, mag_sel(opdata1_i, signed_div_i), 1'b0};
                        end
                    end
                end
                S_BYZERO: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        state   <= S_IDLE;
                        ready_o <= 1'b0;
                    end else begin
                        state   <= S_END;
                        ready_o <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state    <= S_IDLE;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end else if (cnt == 6'd32) begin
                        // All 32 quotient bits are in; apply signs and publish.
                        state    <= S_END;
                        result_o <= {neg_sel(w[64:33], neg_rem), neg_sel(w[31:0], neg_quot)};
                        ready_o  <= 1'b1;
                    end else begin
                        w   <= w_next;
                        cnt <= cnt + 6'd1;
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state    <= S_IDLE;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
